// File: rtl/axi_mem_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : axi_mem_responder                                            |
// | Description : AXI4 subordinate memory model with one outstanding write     |
// |               and one outstanding read, running concurrently.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_mem_responder #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 128,
    parameter int                ID_W      = 6,
    parameter int                MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                io_aclk,
    input  logic                io_areset,
    // write address
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [ID_W-1:0]     awid,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    // write data
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    // write response
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    // read address
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [ID_W-1:0]     arid,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    // read data
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [ID_W-1:0]     rid,
    output logic [1:0]          rresp,
    output logic                rlast
);

    localparam int         c_NB       = DATA_W / 8;
    localparam int         c_LANE_W   = $clog2(c_NB);
    localparam int         c_LW1      = c_LANE_W + 1;
    localparam int         c_MEM_AW   = $clog2(MEM_BYTES);
    localparam int         c_IDX_W    = c_MEM_AW - c_LANE_W;
    localparam int         c_WORDS    = MEM_BYTES / c_NB;
    localparam logic [2:0] c_MAX_SIZE = 3'(c_LANE_W);
    localparam logic [1:0] c_FIXED    = 2'd0;
    localparam logic [1:0] c_WRAP     = 2'd2;
    localparam logic [1:0] c_RSVD     = 2'd3;
    localparam logic [1:0] c_OKAY     = 2'b00;
    localparam logic [1:0] c_SLVERR   = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [2:0] eff_size(input logic [2:0] sz);
        return (sz > c_MAX_SIZE) ? c_MAX_SIZE : sz;
    endfunction

    function automatic logic req_err(input logic [2:0] sz, input logic [1:0] bt);
        return (bt == c_RSVD) || (sz > c_MAX_SIZE);
    endfunction

    // BASE_ADDR is MEM_BYTES-aligned, so the window test is an upper-bit compare
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:c_MEM_AW] == BASE_ADDR[ADDR_W-1:c_MEM_AW];
    endfunction

    function automatic logic [c_IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[c_MEM_AW-1:c_LANE_W];
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0]        sz,
                                                    input logic [7:0]        len,
                                                    input logic [1:0]        bt);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] bound;
        step  = ADDR_W'(1) << eff_size(sz);
        bound = (ADDR_W'(len) + ADDR_W'(1)) << eff_size(sz);
        case (bt)
            c_FIXED: return a;
            c_WRAP:  return (a & ~(bound - ADDR_W'(1))) | ((a + step) & (bound - ADDR_W'(1)));
            default: return (a & ~(step - ADDR_W'(1))) + step;
        endcase
    endfunction

    // Lanes from the true byte address up to the end of its size-aligned block
    function automatic logic [c_NB-1:0] lane_en(input logic [ADDR_W-1:0] a,
                                                input logic [2:0]        sz,
                                                input logic [c_NB-1:0]   strb);
        logic [c_LW1-1:0] lo;
        logic [c_LW1-1:0] step;
        logic [c_LW1-1:0] alo;
        logic [c_NB-1:0]  en;
        lo   = {1'b0, a[c_LANE_W-1:0]};
        step = c_LW1'(1) << eff_size(sz);
        alo  = lo & ~(step - c_LW1'(1));
        for (int l = 0; l < c_NB; l++) begin
            en[l] = strb[l] && (c_LW1'(l) >= lo) && (c_LW1'(l) < (alo + step));
        end
        return en;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [c_WORDS];

    wstate_t           w_state_q,  w_state_d;
    logic [ADDR_W-1:0] waddr_q,    waddr_d;
    logic [ID_W-1:0]   wid_q,      wid_d;
    logic [7:0]        wlen_q,     wlen_d;
    logic [2:0]        wsize_q,    wsize_d;
    logic [1:0]        wburst_q,   wburst_d;
    logic [7:0]        wcnt_q,     wcnt_d;
    logic              werr_q,     werr_d;
    logic              awready_q,  awready_d;
    logic              wready_q,   wready_d;
    logic              bvalid_q,   bvalid_d;
    logic [ID_W-1:0]   bid_q,      bid_d;
    logic [1:0]        bresp_q,    bresp_d;

    rstate_t           r_state_q,  r_state_d;
    logic [ADDR_W-1:0] raddr_q,    raddr_d;
    logic [7:0]        rlen_q,     rlen_d;
    logic [2:0]        rsize_q,    rsize_d;
    logic [1:0]        rburst_q,   rburst_d;
    logic [7:0]        rcnt_q,     rcnt_d;
    logic              rerr_q,     rerr_d;
    logic              arready_q,  arready_d;
    logic              rvalid_q,   rvalid_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic [ID_W-1:0]   rid_q,      rid_d;
    logic [1:0]        rresp_q,    rresp_d;
    logic              rlast_q,    rlast_d;

    logic              mem_we;
    logic [c_NB-1:0]   mem_be;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_word;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wid_d     = wid_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        mem_be    = '0;

        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    waddr_d   = awaddr;
                    wid_d     = awid;
                    wlen_d    = awlen;
                    wsize_d   = awsize;
                    wburst_d  = awburst;
                    wcnt_d    = 8'd0;
                    werr_d    = req_err(awsize, awburst);
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    mem_we  = in_range(waddr_q);
                    mem_be  = lane_en(waddr_q, wsize_q, wstrb);
                    if (!in_range(waddr_q)) begin
                        werr_d = 1'b1;
                    end
                    waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    // Either an early wlast or a missing one ends the burst with an error
                    if (wlast || (wcnt_q == wlen_q)) begin
                        if (wlast != (wcnt_q == wlen_q)) begin
                            werr_d = 1'b1;
                        end
                        w_state_d = W_RESP;
                        bid_d     = wid_q;
                        bresp_d   = werr_d ? c_SLVERR : c_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    w_state_d = W_IDLE;
                    bid_d     = '0;
                    bresp_d   = c_OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge io_aclk) begin
        if (mem_we) begin
            for (int l = 0; l < c_NB; l++) begin
                if (mem_be[l]) begin
                    mem_q[word_idx(waddr_q)][l*8 +: 8] <= wdata[l*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign rd_addr = (r_state_q == R_IDLE) ? araddr
                                           : next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
    assign rd_ok   = in_range(rd_addr);
    assign rd_word = mem_q[word_idx(rd_addr)];

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;

        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    raddr_d   = araddr;
                    rlen_d    = arlen;
                    rsize_d   = arsize;
                    rburst_d  = arburst;
                    rcnt_d    = 8'd0;
                    rerr_d    = req_err(arsize, arburst);
                    rvalid_d  = 1'b1;
                    rid_d     = arid;
                    rdata_d   = rd_ok ? rd_word : '0;
                    rresp_d   = (req_err(arsize, arburst) || !rd_ok) ? c_SLVERR : c_OKAY;
                    rlast_d   = (arlen == 8'd0);
                end
            end
            R_DATA: begin
                if (rready && rvalid_q) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdata_d   = '0;
                        rid_d     = '0;
                        rresp_d   = c_OKAY;
                    end else begin
                        raddr_d = rd_addr;
                        rcnt_d  = rcnt_q + 8'd1;
                        rdata_d = rd_ok ? rd_word : '0;
                        rresp_d = (rerr_q || !rd_ok) ? c_SLVERR : c_OKAY;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge io_aclk or posedge io_areset) begin
        if (io_areset) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wid_q     <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wid_q     <= wid_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rerr_q    <= rerr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_mem_responder                                         |
// | Description : Directed self-checking bench for axi_mem_responder.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axi_mem_responder;

    logic         io_aclk   = 1'b0;
    logic         io_areset = 1'b1;
    logic         awvalid = 1'b0, awready;
    logic [31:0]  awaddr  = '0;
    logic [5:0]   awid    = '0;
    logic [7:0]   awlen   = '0;
    logic [2:0]   awsize  = '0;
    logic [1:0]   awburst = '0;
    logic         wvalid = 1'b0, wready;
    logic [127:0] wdata  = '0;
    logic [15:0]  wstrb  = '0;
    logic         wlast  = 1'b0;
    logic         bvalid, bready = 1'b0;
    logic [5:0]   bid;
    logic [1:0]   bresp;
    logic         arvalid = 1'b0, arready;
    logic [31:0]  araddr  = '0;
    logic [5:0]   arid    = '0;
    logic [7:0]   arlen   = '0;
    logic [2:0]   arsize  = '0;
    logic [1:0]   arburst = '0;
    logic         rvalid, rready = 1'b0;
    logic [127:0] rdata;
    logic [5:0]   rid;
    logic [1:0]   rresp;
    logic         rlast;

    int checks = 0;
    int errors = 0;

    axi_mem_responder dut (
        .io_aclk(io_aclk),   .io_areset(io_areset),
        .awvalid(awvalid),   .awready(awready),   .awaddr(awaddr), .awid(awid),
        .awlen(awlen),       .awsize(awsize),     .awburst(awburst),
        .wvalid(wvalid),     .wready(wready),     .wdata(wdata),   .wstrb(wstrb),
        .wlast(wlast),
        .bvalid(bvalid),     .bready(bready),     .bid(bid),       .bresp(bresp),
        .arvalid(arvalid),   .arready(arready),   .araddr(araddr), .arid(arid),
        .arlen(arlen),       .arsize(arsize),     .arburst(arburst),
        .rvalid(rvalid),     .rready(rready),     .rdata(rdata),   .rid(rid),
        .rresp(rresp),       .rlast(rlast)
    );

    always #5 io_aclk = ~io_aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic step();
        @(posedge io_aclk);
        #1;
    endtask

    function automatic logic [127:0] d_word(input int i);
        logic [127:0] base;
        base = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EE00;
        return base + 128'(i);
    endfunction

    task automatic send_aw(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bt;
        @(negedge io_aclk);
        chk("awready", awready, 1);
        step();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [127:0] d, input logic [15:0] s, input logic last);
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
        @(negedge io_aclk);
        chk("wready", wready, 1);
        step();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic expect_b(input logic [1:0] resp, input logic [5:0] id);
        bready = 1'b1;
        @(negedge io_aclk);
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, resp);
        chk("bid", bid, id);
        step();
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = sz; arburst = bt;
        @(negedge io_aclk);
        chk("arready", arready, 1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic expect_r(input logic [127:0] d, input logic [1:0] resp, input logic last,
                            input logic [5:0] id);
        rready = 1'b1;
        @(negedge io_aclk);
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, d);
        chk("rresp", rresp, resp);
        chk("rlast", rlast, last);
        chk("rid", rid, id);
        step();
        rready = 1'b0;
    endtask

    task automatic stall_r(input logic [127:0] d, input logic last);
        rready = 1'b0;
        @(negedge io_aclk);
        chk("rvalid_hold", rvalid, 1);
        chk("rdata_hold", rdata, d);
        chk("rlast_hold", rlast, last);
        step();
    endtask

    task automatic write1(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                          input logic [5:0] id);
        send_aw(a, id, 8'd0, 3'd4, 2'd1);
        send_w(d, s, 1'b1);
        expect_b(2'b00, id);
    endtask

    task automatic read1(input logic [31:0] a, input logic [127:0] d, input logic [1:0] resp);
        send_ar(a, 6'h05, 8'd0, 3'd4, 2'd1);
        expect_r(d, resp, 1'b1, 6'h05);
    endtask

    initial begin
        // reset state
        @(negedge io_aclk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        step();
        io_areset = 1'b0;
        step();
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);

        // single write then read
        write1(32'h100, {16{8'hA5}}, 16'hFFFF, 6'h11);
        read1(32'h100, {16{8'hA5}}, 2'b00);

        // INCR burst with read backpressure
        send_aw(32'h200, 6'h22, 8'd3, 3'd4, 2'd1);
        for (int i = 0; i < 4; i++) send_w(d_word(i), 16'hFFFF, i == 3);
        expect_b(2'b00, 6'h22);
        send_ar(32'h200, 6'h23, 8'd3, 3'd4, 2'd1);
        for (int i = 0; i < 4; i++) begin
            stall_r(d_word(i), i == 3);
            expect_r(d_word(i), 2'b00, i == 3, 6'h23);
        end
        chk("incr_rvalid_end", rvalid, 0);
        chk("incr_arready_end", arready, 1);

        // WRAP read: 0x130, 0x100, 0x110, 0x120
        send_aw(32'h110, 6'h24, 8'd2, 3'd4, 2'd1);
        send_w({16{8'h11}}, 16'hFFFF, 1'b0);
        send_w({16{8'h12}}, 16'hFFFF, 1'b0);
        send_w({16{8'h13}}, 16'hFFFF, 1'b1);
        expect_b(2'b00, 6'h24);
        send_ar(32'h130, 6'h25, 8'd3, 3'd4, 2'd2);
        expect_r({16{8'h13}}, 2'b00, 1'b0, 6'h25);
        expect_r({16{8'hA5}}, 2'b00, 1'b0, 6'h25);
        expect_r({16{8'h11}}, 2'b00, 1'b0, 6'h25);
        expect_r({16{8'h12}}, 2'b00, 1'b1, 6'h25);

        // single-byte strobe over a zeroed word
        write1(32'h300, 128'h0, 16'hFFFF, 6'h26);
        write1(32'h300, {16{8'hFF}}, 16'h0001, 6'h27);
        read1(32'h300, 128'hFF, 2'b00);

        // out-of-window write must not alias onto word 0
        write1(32'h0, {16{8'h77}}, 16'hFFFF, 6'h30);
        send_aw(32'h0001_0000, 6'h31, 8'd0, 3'd4, 2'd1);
        send_w({16{8'h5A}}, 16'hFFFF, 1'b1);
        expect_b(2'b10, 6'h31);
        read1(32'h0, {16{8'h77}}, 2'b00);

        // early wlast on beat 1 of a 4-beat burst
        send_aw(32'h400, 6'h32, 8'd3, 3'd4, 2'd1);
        send_w({16{8'h44}}, 16'hFFFF, 1'b0);
        send_w({16{8'h45}}, 16'hFFFF, 1'b1);
        expect_b(2'b10, 6'h32);

        // missing wlast on the final beat
        send_aw(32'h500, 6'h34, 8'd0, 3'd4, 2'd1);
        send_w({16{8'h55}}, 16'hFFFF, 1'b0);
        expect_b(2'b10, 6'h34);

        // out-of-window read
        send_ar(32'h0001_0000, 6'h33, 8'd0, 3'd4, 2'd1);
        expect_r(128'h0, 2'b10, 1'b1, 6'h33);

        // reset during beat 2 of an 8-beat read
        send_ar(32'h200, 6'h35, 8'd7, 3'd4, 2'd1);
        expect_r(d_word(0), 2'b00, 1'b0, 6'h35);
        expect_r(d_word(1), 2'b00, 1'b0, 6'h35);
        #2;
        io_areset = 1'b1;
        #1;
        chk("async_rst_rvalid", rvalid, 0);
        chk("async_rst_arready", arready, 0);
        step();
        io_areset = 1'b0;
        step();
        chk("rel_arready", arready, 1);
        chk("rel_rvalid", rvalid, 0);
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale_rvalid", rvalid, 0);
        end
        rready = 1'b0;

        // array contents survive reset
        read1(32'h200, d_word(0), 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 subordinate (responder) memory model that terminates the RVV core's manager AXI port (m_* channels). It replaces static tie-offs in top-level benches and FPGA bring-up.
- Accepts AW/W/AR requests, stores write data in an internal byte-addressable array, and returns B and R responses.
- Supports one outstanding write and one outstanding read at a time. The read and write paths run concurrently.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 128, data width in bits; power of two, ≥32.
- ID_W, 6, AXI ID width.
- MEM_BYTES, 65536, array size in bytes; power of two.
- BASE_ADDR, 32'h0000_0000, first decoded address; MEM_BYTES-aligned.

Ports:
- io_aclk  in  1  clock.
- io_areset  in  1  asynchronous, active-high reset.
- awvalid/awready  in/out  1  AW handshake.
- awaddr  in  ADDR_W  write burst start address.
- awid  in  ID_W  write ID.
- awlen  in  8  beats minus 1.
- awsize  in  3  log2 bytes per beat.
- awburst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
- wvalid/wready  in/out  1  W handshake.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte enables.
- wlast  in  1  last write beat.
- bvalid/bready  out/in  1  B handshake.
- bid  out  ID_W  write response ID.
- bresp  out  2  write response.
- arvalid/arready  in/out  1  AR handshake.
- araddr  in  ADDR_W  read burst start address.
- arid  in  ID_W  read ID.
- arlen  in  8  beats minus 1.
- arsize  in  3  log2 bytes per beat.
- arburst  in  2  burst type.
- rvalid/rready  out/in  1  R handshake.
- rdata  out  DATA_W  read data.
- rid  out  ID_W  read ID.
- rresp  out  2  read response.
- rlast  out  1  last read beat.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0; both FSMs go to IDLE.
  - Array contents are not cleared.
  - Reset mid-burst abandons the burst; no B or R is issued afterwards.
- Write FSM, states W_IDLE → W_DATA → W_RESP → W_IDLE:
  - awready=1 only in W_IDLE. The AW handshake latches id, addr, len, size and burst, clears the error flag, and moves to W_DATA.
  - wready=1 only in W_DATA, so the first beat is accepted at the earliest 1 cycle after AW.
  - Each accepted beat writes bytes whose wstrb bit is set and whose lane lies within the active size window at the current address.
  - Error flag set: beat address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES). That beat's write is suppressed.
  - Error flag set: wlast=1 before the beat counter reaches len. Go to W_RESP immediately.
  - Error flag set: wlast=0 on the final counted beat. Go to W_RESP anyway; later W beats wait for the next AW.
  - W_RESP: bvalid=1 starting the cycle after the last W handshake. bresp is 2'b10 (SLVERR) if the error flag is set, else 2'b00. Hold until bready, then return to W_IDLE.
- Read FSM, states R_IDLE → R_DATA → R_IDLE:
  - arready=1 only in R_IDLE. The AR handshake latches the request.
  - The first beat is presented with rvalid=1 the cycle after AR (1-cycle latency).
  - Beats stream back-to-back while rready=1. rvalid, rdata, rid, rresp and rlast hold stable while rready=0.
  - rlast=1 on beat len. After the last handshake, return to R_IDLE; arready rises the next cycle.
  - Out-of-range beat: rdata=0, rresp=SLVERR for that beat only.
- Address generation (both paths, beat size 2^size bytes):
  - FIXED: address is constant.
  - INCR: address += 2^size. Wrap-around of ADDR_W is ignored and never produced by legal stimulus.
  - WRAP: boundary = (len+1)*2^size. Address = (addr & ~(boundary-1)) | ((addr + 2^size) & (boundary-1)).
  - Unaligned INCR start: the first beat uses its true byte address; later beats are size-aligned.
  - burst=3 (reserved): treat as INCR and flag SLVERR.
  - size > log2(DATA_W/8): flag SLVERR; data is written and read as full bus width.
- Byte-lane mapping: array byte address A maps to lane A mod (DATA_W/8).
- Simultaneous read and write to the same address: an R beat loaded in the same cycle as a W write returns the old data (read-before-write). The next beat sees the new data.
- The read and write FSMs are independent; simultaneous AW and AR handshakes are both accepted.

Test Plan:
- Single write then read:
  - AW addr=0x100, len=0, size=4, INCR; W data=0xA5…A5, strb=all-ones.
  - Required: bvalid 1 cycle after W, bresp=0, bid=awid.
  - Then AR addr=0x100: rvalid 1 cycle after AR, rdata=0xA5…A5, rlast=1, rresp=0.
- INCR burst with backpressure:
  - AW len=3 at 0x200, four distinct words, then AR len=3.
  - Toggle rready 1/0 each cycle.
  - Required: 4 beats in order, data held stable while rready=0, rlast only on beat 3.
- WRAP burst:
  - AR addr=0x130, len=3, size=4.
  - Required: beat addresses 0x130, 0x100, 0x110, 0x120.
- Strobes:
  - Write wstrb=0x0001 with data=0x…FF over a word prefilled with 0.
  - Required: readback low byte 0xFF, all other bytes unchanged.
- Errors:
  - AW addr=BASE_ADDR+MEM_BYTES → bresp=2'b10 and the array is unchanged.
  - AW len=3 with wlast on beat 1 → bresp=2'b10 issued the cycle after beat 1.
  - AR outside the window → rdata=0, rresp=2'b10.
- Reset mid-read:
  - Assert io_areset during beat 2 of a len=7 read.
  - Required: rvalid=0 immediately (asynchronously), arready=1 the cycle after release, no stale beats.
